audio_stream_out: RTL

- Parametrised multichannel PCM-to-1-bit audio output stage.
- Accepts packed multichannel frames through a valid/ready handshake into a small FIFO.
- Pops one frame per sample period, set by an internal divider from the system clock (no PLL).
- Drives one first-order delta-sigma modulator per channel.
- Sits between the audio source (synth/mixer) and the board's 1-bit DAC pins.
- Adds over the previous stereo block: a configurable channel count, buffering, a selectable underrun policy, and underrun reporting.

---
 rtl/audio_stream_out.sv | 136 +++++++++++++
 1 files changed

// File: rtl/audio_stream_out.sv
// Multichannel PCM to 1-bit audio output stage.
// Frames enter a small FIFO through a valid/ready handshake. One frame is popped
// per sample period, and each channel drives a first-order delta-sigma modulator.
module audio_stream_out #(
  parameter int AUDIO_BITS = 12,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DIV = 4096
) (
  input  logic                             clk,
  input  logic                             aclr,
  input  logic                             enable,
  input  logic                             hold_mode,
  input  logic                             in_valid,
  input  logic [CHANNELS*AUDIO_BITS-1:0]   in_frame,
  output logic                             in_ready,
  output logic [CHANNELS-1:0]              dac_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             sample_tick,
  output logic                             underrun,
  output logic [15:0]                      underrun_count
);

  localparam int FRAME_W = CHANNELS * AUDIO_BITS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  // Saturating increment for the underrun counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [FRAME_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      div_cnt;
  logic [FRAME_W-1:0]    head_frame;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  logic [AUDIO_BITS-1:0] pcm_p0 [CHANNELS];
  logic [AUDIO_BITS-1:0] acc_p1 [CHANNELS];
  logic [AUDIO_BITS:0]   sum_p1 [CHANNELS];

  // Full and empty come from the registered level. A pop in the same cycle
  // therefore never makes room for a push into a full FIFO, and a push into an
  // empty FIFO is never popped in the same cycle.
  assign full        = (fifo_level == LVL_FULL);
  assign empty       = (fifo_level == '0);
  assign in_ready    = !full && !aclr;
  assign push        = in_valid && in_ready;
  assign sample_tick = !aclr && enable && (div_cnt == CNT_LAST);
  assign underrun    = sample_tick && empty;
  assign pop         = sample_tick && !empty;
  assign head_frame  = fifo_mem[rd_ptr];

  // Sample-period divider: free-runs while enabled and freezes while paused.
  always_ff @(posedge clk) begin
    if (aclr) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= sample_tick ? '0 : div_cnt + 1'b1;
    end
  end

  // FIFO control: pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage: write-only on push. Stale contents are never read, so there is no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_frame;
  end

  // Underrun counter: saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (aclr) begin
      underrun_count <= '0;
    end else if (underrun) begin
      underrun_count <= sat_inc16(underrun_count);
    end
  end

  // ---- stage p0: per-channel PCM registers loaded on a tick ----
  // Channel 0 sits in the frame MSBs. On underrun the policy picks zero or hold.
  always_ff @(posedge clk) begin
    if (aclr) begin
      for (int c = 0; c < CHANNELS; c++) pcm_p0[c] <= '0;
    end else if (pop) begin
      for (int c = 0; c < CHANNELS; c++)
        pcm_p0[c] <= head_frame[(CHANNELS-1-c)*AUDIO_BITS +: AUDIO_BITS];
    end else if (underrun && !hold_mode) begin
      for (int c = 0; c < CHANNELS; c++) pcm_p0[c] <= '0;
    end
  end

  // ---- stage p1: first-order delta-sigma, carry out is the 1-bit output ----
  // Unsigned accumulate with one extra bit. The carry is the output pulse.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      sum_p1[c] = {1'b0, acc_p1[c]} + {1'b0, pcm_p0[c]};
  end

  // Accumulator and output bit update every cycle, independent of enable.
  always_ff @(posedge clk) begin
    if (aclr) begin
      for (int c = 0; c < CHANNELS; c++) acc_p1[c] <= '0;
      dac_out <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_p1[c]  <= sum_p1[c][AUDIO_BITS-1:0];
        dac_out[c] <= sum_p1[c][AUDIO_BITS];
      end
    end
  end

endmodule
